// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
// Imported by the multiplier top level.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 10;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mult_acc_register.sv
// A/Q accumulator pair: add the multiplicand when Q[0] is set,
// then shift {C,A,Q} right by one. The dual of the divider's accumulator.
module mult_acc_register #(
    parameter int WIDTH = 10
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] nxt_o
);

    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   s;

    // a_q[WIDTH] is always zero after a shift, so the sum never overflows
    always_comb begin
        s   = a_q + (q_q[0] ? {1'b0, m_q} : '0);
        a_d = {1'b0, s[WIDTH:1]};
        q_d = {s[0], q_q[WIDTH-1:1]};
    end

    assign nxt_o = {a_d[WIDTH-1:0], q_d};

    always_ff @(posedge clock) begin
        if (rst) begin
            m_q <= '0;
            a_q <= '0;
            q_q <= '0;
        end else if (load_i) begin
            m_q <= mcand_i;
            a_q <= '0;
            q_q <= mplier_i;
        end else if (step_i) begin
            a_q <= a_d;
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one partial product per clock,
// start/done handshake shared with the divider.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               load, step;

    mult_acc_register #(.WIDTH(WIDTH)) u_acc (
        .clock    (clock),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (multiplicand),
        .mplier_i (multiplier),
        .nxt_o    (acc_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // capture the post-shift value on the final iteration
                if (cnt_q == LAST) begin
                    prod_d  = acc_nxt;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and randomized checks of shift_add_multiplier against
// a plain-arithmetic product model.
module tb_shift_add_multiplier;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  multiplicand = '0;
    logic [9:0]  multiplier = '0;
    logic        busy;
    logic        done;
    logic [19:0] product;

    int total = 0;
    int passed = 0;
    int stab_err = 0;
    int ovl_err = 0;
    logic [19:0] prev_prod = '0;

    shift_add_multiplier #(.WIDTH(10)) dut (
        .clock        (clock),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin : mon
        logic r;
        r = rst;
        #1;
        if (!r && product !== prev_prod && !done) stab_err++;
        if (busy && done) ovl_err++;
        prev_prod = product;
    end

    function automatic logic [19:0] model(input logic [9:0] m, input logic [9:0] q);
        return 20'(m) * 20'(q);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_op(input string tag, input logic [9:0] m, input logic [9:0] q,
                         input bit disturb, input int rst_at,
                         input int exp_done, input int exp_busy);
        int lat, bc, dc;
        logic [19:0] got;
        lat = 0; bc = 0; dc = 0; got = '0;
        @(negedge clock);
        multiplicand = m;
        multiplier = q;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        multiplicand = 10'($urandom);
        multiplier = 10'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (disturb) begin
                start = (i == 4 || i == 11);
                multiplicand = 10'd1;
                multiplier = 10'd1;
            end
            if (i == rst_at) rst = 1'b1;
            if (rst_at > 0 && i == rst_at + 1) begin
                check({tag, "_rst_busy"}, 32'(busy), 0);
                check({tag, "_rst_done"}, 32'(done), 0);
                check({tag, "_rst_prod"}, 32'(product), 0);
                rst = 1'b0;
            end
            if (busy) bc++;
            if (done) begin
                dc++;
                if (lat == 0) lat = i;
                got = product;
            end
        end
        start = 1'b0;
        check({tag, "_dones"}, dc, exp_done);
        check({tag, "_busy"}, bc, exp_busy);
        if (exp_done == 1) begin
            check({tag, "_lat"}, lat, 11);
            check({tag, "_prod"}, 32'(got), 32'(model(m, q)));
        end
    endtask

    initial begin
        int times[$];
        logic [19:0] held;
        logic [9:0] rm, rq;

        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_prod", 32'(product), 0);
        rst = 1'b0;

        do_op("basic", 10'd5, 10'd3, 1'b0, 0, 1, 10);
        do_op("carry", 10'h3FF, 10'h3FF, 1'b0, 0, 1, 10);
        check("carry_val", 32'(product), 32'h000FF801);
        do_op("zero", 10'd0, 10'h2AA, 1'b0, 0, 1, 10);
        do_op("ident", 10'h3FF, 10'd1, 1'b0, 0, 1, 10);

        held = model(10'h3FF, 10'd1);
        repeat (5) @(negedge clock);
        check("hold_prod", 32'(product), 32'(held));

        do_op("busy_start", 10'd7, 10'd9, 1'b1, 0, 1, 10);
        check("busy_start_idle", 32'(busy), 0);

        do_op("mid_rst", 10'd100, 10'd200, 1'b0, 4, 0, 4);
        do_op("after_rst", 10'd2, 10'd3, 1'b0, 0, 1, 10);

        @(negedge clock);
        multiplicand = 10'd10;
        multiplier = 10'd10;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (done) begin
                times.push_back(i);
                check("b2b_prod", 32'(product), 32'(model(10'd10, 10'd10)));
            end
        end
        start = 1'b0;
        check("b2b_count", times.size(), 3);
        for (int k = 1; k < times.size(); k++)
            check("b2b_interval", times[k] - times[k-1], 12);
        repeat (20) @(negedge clock);

        start = 1'b1;
        rst = 1'b1;
        multiplicand = 10'd3;
        multiplier = 10'd3;
        @(negedge clock);
        check("rst_wins_busy", 32'(busy), 0);
        check("rst_wins_prod", 32'(product), 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_wins_idle", 32'(busy), 0);

        for (int n = 0; n < 15; n++) begin
            rm = 10'($urandom);
            rq = 10'($urandom);
            do_op("rand", rm, rq, 1'b0, 0, 1, 10);
        end

        check("prod_stable", stab_err, 0);
        check("busy_done_excl", ovl_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-and-add multiplier: the multiply counterpart of the restoring divider's accumulator/quotient datapath. It accepts two WIDTH-bit operands on a start pulse and iterates one partial product per clock. It returns a 2·WIDTH-bit product with a one-cycle done pulse. It sits beside the divider in the arithmetic unit and shares its start/done handshake style.

## Interface
- WIDTH, 10, operand width in bits; product is 2·WIDTH bits.
- clock  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  operand M, captured on accepted start.
- multiplier  input  WIDTH  operand Q, captured on accepted start.
- busy  output  1  high while iterating (CALC).
- done  output  1  one-cycle pulse; product valid.
- product  output  2·WIDTH  registered result, held until the next done.

## Operation
- Internal regs:
  - M (WIDTH).
  - A (WIDTH+1, MSB is carry C).
  - Q (WIDTH).
  - cnt (clog2(WIDTH+1) bits).
  - state.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On start=1: M←multiplicand, Q←multiplier, A←0, cnt←0, go to CALC.
  - Otherwise hold.
- CALC, per cycle:
  - S = Q[0] ? A[WIDTH-1:0] + M : A[WIDTH-1:0] (WIDTH+1-bit sum, carry in S[WIDTH]).
  - Then {A,Q} ← {1'b0, S, Q} >> 1; i.e. A←{0,S[WIDTH:1]}, Q←{S[0],Q[WIDTH-1:1]}.
  - cnt←cnt+1.
  - When cnt==WIDTH-1 (last iteration), go to DONE and load product from the post-shift {A[WIDTH-1:0],Q}.
- DONE:
  - done=1 for exactly this cycle.
  - Unconditionally return to IDLE.
- start is ignored in CALC and DONE. No queuing; the request is simply lost.
- Operand inputs are only sampled on the accepted start. Later changes have no effect.
- Arithmetic is unsigned and modulo-free: the full 2·WIDTH product is always exact. Carry out of the add is retained in C before the shift.
- Reset at any time, including mid-CALC:
  - state←IDLE.
  - A, Q, M, cnt, product ← 0.
  - busy=0, done=0.
  - The aborted operation produces no done.

## Timing
- Reset values: busy=0, done=0, product=0.
- Start accepted at edge E0. CALC occupies the cycles after edges E0…E(WIDTH-1), so busy is high for WIDTH cycles.
- At edge E(WIDTH), product is updated and done rises for one cycle. Latency is WIDTH+1 cycles from the accepting edge to done visible (11 for WIDTH=10).
- busy and done are never high together.
- The next start is accepted no earlier than the cycle after done, i.e. in IDLE. Minimum issue interval is WIDTH+2 cycles.
- product changes only at the edge that raises done. It is stable at all other times.
- start and rst high on the same edge: rst wins.

## Structure
- Shared package mult_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - default WIDTH constant;
  - CNT_W = clog2(WIDTH+1).
- Natural sub-module mult_acc_register implements the datapath:
  - the A/Q register pair with clear, load, and add-then-shift-right control;
  - it is the multiply dual of the divider's shift-left accumulator.
- The top level holds the FSM, counter and product register only.

## Test plan
- Basic: reset, then start with M=5, Q=3 → busy high 10 cycles; done pulses at cycle 11; product=15.
- Carry path: M=0x3FF, Q=0x3FF → product=0xFF801 (1046529). C bit must propagate every iteration.
- Zero and identity:
  - M=0, Q=0x2AA → product=0.
  - M=0x3FF, Q=1 → product=0x3FF.
  - product holds between operations.
- Start while busy: start at E0 (M=7, Q=9), pulse start again with M=1, Q=1 mid-CALC and during DONE → single done, product=63, second request dropped.
- Reset mid-op: start M=100, Q=200, assert rst after 4 CALC cycles → next cycle busy=0, done=0, product=0; no done follows. A new start (M=2, Q=3) then gives product=6.
- Back-to-back: start held high continuously with M=10, Q=10 → done pulses every 12 cycles; product=100 each time.
